// File: rtl/grid_pkg.sv
// Shared grid-side constants, event types and the grid-to-sensor conversion
// used by the spatial expander and other grid event consumers.
package grid_pkg;

  localparam int SENSOR_RES = 320;
  localparam int GRID_SIZE  = 16;
  localparam int GRID_BITS  = 4;
  localparam int CENTER     = GRID_SIZE / 2;
  localparam int CELL_PITCH = SENSOR_RES / GRID_SIZE;
  localparam int COORD_BITS = 9;

  typedef logic signed [GRID_BITS:0] grid_pos_t;
  typedef logic [COORD_BITS-1:0]     coord_t;

  localparam grid_pos_t POS_MIN = grid_pos_t'(-CENTER);
  localparam grid_pos_t POS_MAX = grid_pos_t'(CENTER - 1);

  typedef struct packed {
    grid_pos_t x;
    grid_pos_t y;
    logic      polarity;
  } grid_evt_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   polarity;
  } sensor_evt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic in_grid_range(input grid_pos_t pos);
    return (pos >= POS_MIN) && (pos <= POS_MAX);
  endfunction

  // Cell centre of a signed grid position; g*20 is built as g*16 + g*4,
  // so these shift amounts are tied to a pitch of 20.
  function automatic coord_t grid_to_sensor(input grid_pos_t pos);
    logic [GRID_BITS:0] biased;
    coord_t             g;
    biased = $unsigned(pos) + (GRID_BITS+1)'(CENTER);
    g      = {{(COORD_BITS-GRID_BITS){1'b0}}, biased[GRID_BITS-1:0]};
    return (g << 4) + (g << 2) + coord_t'(CELL_PITCH / 2);
  endfunction

endpackage

// File: rtl/grid_event_fifo.sv
// Small synchronous FIFO of grid events; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, otherwise it is reported as a drop.
module grid_event_fifo
  import grid_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  grid_evt_t push_data_i,
  input  logic      pop_i,
  output grid_evt_t pop_data_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  grid_evt_t   mem_q [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    drop_o   = push_i && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage needs no reset; resetting the pointers empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/spatial_expander.sv
// Expands signed grid-relative events into sensor-space cell centres, with an
// input FIFO, a single output register and saturating drop/range statistics.
module spatial_expander
  import grid_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic signed [GRID_BITS:0] in_x,
  input  logic signed [GRID_BITS:0] in_y,
  input  logic                  in_polarity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic                  out_polarity,
  input  logic                  clr_stats,
  output logic                  overflow,
  output logic [CNT_BITS-1:0]   drop_count,
  output logic [CNT_BITS-1:0]   range_err_count
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic        in_range, push, range_err, drop;
  logic        load, fifo_full, fifo_empty;
  grid_evt_t   in_evt, head_evt;

  out_state_e  state_q, state_d;
  sensor_evt_t out_evt_q, out_evt_d;

  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_BITS-1:0] rerr_cnt_q, rerr_cnt_d;
  logic                overflow_q, overflow_d;

  assign in_range  = in_grid_range(in_x) && in_grid_range(in_y);
  assign push      = in_valid && in_range;
  assign range_err = in_valid && !in_range;
  assign in_evt    = '{x: in_x, y: in_y, polarity: in_polarity};

  // The output register refills whenever it is empty or being consumed.
  assign load = !fifo_empty && ((state_q == OUT_EMPTY) || out_ready);

  grid_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (in_evt),
    .pop_i       (load),
    .pop_data_o  (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (out_ready && !load) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    out_valid    = (state_q == OUT_FULL);
    out_x        = out_evt_q.x;
    out_y        = out_evt_q.y;
    out_polarity = out_evt_q.polarity;
  end

  always_comb begin
    out_evt_d = out_evt_q;
    if (load) begin
      out_evt_d = '{x:        grid_to_sensor(head_evt.x),
                    y:        grid_to_sensor(head_evt.y),
                    polarity: head_evt.polarity};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_evt_q <= '0;
    else        out_evt_q <= out_evt_d;
  end

  // Clear takes priority over any increment in the same cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rerr_cnt_d = rerr_cnt_q;
    overflow_d = overflow_q;
    if (clr_stats) begin
      drop_cnt_d = '0;
      rerr_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
      end
      if (range_err && (rerr_cnt_q != CNT_MAX)) rerr_cnt_d = rerr_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      rerr_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rerr_cnt_q <= rerr_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_count      = drop_cnt_q;
  assign range_err_count = rerr_cnt_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_spatial_expander.sv
// Self-checking bench for spatial_expander: table vectors, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_spatial_expander;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [4:0] in_x = '0;
  logic signed [4:0] in_y = '0;
  logic              in_polarity = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_stats = 1'b0;
  logic              out_valid;
  logic [8:0]        out_x, out_y;
  logic              out_polarity;
  logic              overflow;
  logic [7:0]        drop_count, range_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  spatial_expander #(
    .FIFO_DEPTH (4),
    .CNT_BITS   (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_x            (in_x),
    .in_y            (in_y),
    .in_polarity     (in_polarity),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_x           (out_x),
    .out_y           (out_y),
    .out_polarity    (out_polarity),
    .clr_stats       (clr_stats),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .range_err_count (range_err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int x;
    int y;
    bit p;
    int ex;
    int ey;
  } vec_t;

  typedef struct {
    int x;
    int y;
    bit p;
  } mevt_t;

  // Reference model state: FIFO contents, output slot and statistics.
  mevt_t m_fifo[$];
  bit    m_ov;
  mevt_t m_out;
  int    m_drop, m_rerr;
  bit    m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int centre(input int pos);
    return (pos + 8) * 20 + 10;
  endfunction

  function automatic logic [19:0] pk(input bit v, input int x, input int y, input bit p);
    return {v, 9'(x), 9'(y), p};
  endfunction

  function automatic logic [19:0] dut_pk();
    return {out_valid, out_x, out_y, out_polarity};
  endfunction

  task automatic drive(input bit v, input int x, input int y, input bit p);
    in_valid    = v;
    in_x        = 5'(x);
    in_y        = 5'(y);
    in_polarity = p;
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && out_valid; i++) tick();
    check("drain_done", out_valid, 1'b0);
  endtask

  // Sends one event into an idle pipeline and checks the two-edge latency.
  task automatic single_event(input string name, input int x, input int y, input bit p);
    out_ready = 1'b1;
    drive(1, x, y, p);
    tick();
    drive(0, 0, 0, 0);
    check({name, "_not_yet"}, out_valid, 1'b0);
    tick();
    check({name, "_out"}, dut_pk(), pk(1, centre(x), centre(y), p));
    tick();
    check({name, "_one_cycle"}, out_valid, 1'b0);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ov   = 0;
    m_drop = 0;
    m_rerr = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input bit v, input int x, input int y, input bit p,
                            input bit rdy, input bit clr);
    bit    full, pop;
    mevt_t e;
    full = (m_fifo.size() == 4);
    pop  = (m_fifo.size() != 0) && (!m_ov || rdy);
    if (pop) begin
      m_out = m_fifo.pop_front();
      m_ov  = 1;
    end else if (rdy) begin
      m_ov = 0;
    end
    if (v) begin
      if (x < -8 || x > 7 || y < -8 || y > 7) begin
        if (m_rerr < 255) m_rerr++;
      end else if (!full || pop) begin
        e.x = x; e.y = y; e.p = p;
        m_fifo.push_back(e);
      end else begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1;
      end
    end
    if (clr) begin
      m_drop = 0;
      m_rerr = 0;
      m_ovf  = 0;
    end
  endtask

  initial begin
    vec_t  vecs[5];
    mevt_t sent[$];
    int    got, stale;

    vecs[0] = '{x: -8, y:  7, p: 1, ex:  10, ey: 310};
    vecs[1] = '{x:  0, y:  0, p: 0, ex: 170, ey: 170};
    vecs[2] = '{x:  7, y: -8, p: 0, ex: 310, ey:  10};
    vecs[3] = '{x: -1, y:  1, p: 1, ex: 150, ey: 190};
    vecs[4] = '{x:  3, y: -5, p: 1, ex: 230, ey:  70};

    // Reset state
    #3;
    check("rst_out", dut_pk(), 20'd0);
    check("rst_stats", {overflow, drop_count, range_err_count}, 17'd0);
    do_reset();
    check("rst_out_after", dut_pk(), 20'd0);

    // Table vectors
    foreach (vecs[i]) begin
      out_ready = 1'b1;
      drive(1, vecs[i].x, vecs[i].y, vecs[i].p);
      tick();
      drive(0, 0, 0, 0);
      check("vec_latency", out_valid, 1'b0);
      tick();
      check("vec_out", dut_pk(), pk(1, vecs[i].ex, vecs[i].ey, vecs[i].p));
      tick();
      check("vec_one_cycle", out_valid, 1'b0);
    end

    // Full sweep, back to back
    out_ready = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) drive(1, i / 16 - 8, i % 16 - 8, i[0]);
      else         drive(0, 0, 0, 0);
      tick();
      if (i > 0) begin
        check("sweep", dut_pk(),
              pk(1, centre((i - 1) / 16 - 8), centre((i - 1) % 16 - 8), (i - 1) % 2 == 1));
      end
    end
    tick();
    check("sweep_end", out_valid, 1'b0);

    // Range errors
    pulse_clr();
    stale = 0;
    drive(1, 8, 0, 1);
    tick();
    stale += out_valid;
    drive(1, 0, -9, 0);
    tick();
    stale += out_valid;
    drive(0, 0, 0, 0);
    check("rerr_count", range_err_count, 8'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      stale += out_valid;
    end
    check("rerr_no_output", stale, 0);
    single_event("rerr_fifo_clean", 2, -2, 1);

    // Overflow with stalled output
    pulse_clr();
    out_ready = 1'b0;
    sent.delete();
    for (int i = 0; i < 7; i++) begin
      drive(1, i - 3, -i, i[0]);
      if (i < 5) sent.push_back('{x: i - 3, y: -i, p: i[0]});
      tick();
    end
    drive(0, 0, 0, 0);
    check("ovf_drops", drop_count, 8'd2);
    check("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_stall_stable", dut_pk(), pk(1, centre(-3), centre(0), 0));
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (got < 5) begin
          check("ovf_order", dut_pk(),
                pk(1, centre(sent[got].x), centre(sent[got].y), sent[got].p));
        end
        got++;
      end
      tick();
    end
    check("ovf_count", got, 5);

    // Full FIFO push with simultaneous pop
    pulse_clr();
    out_ready = 1'b0;
    sent.delete();
    for (int i = 0; i < 6; i++) sent.push_back('{x: 7 - i, y: i - 8, p: ~i[0]});
    for (int i = 0; i < 5; i++) begin
      drive(1, sent[i].x, sent[i].y, sent[i].p);
      tick();
    end
    check("pp_head", dut_pk(), pk(1, centre(sent[0].x), centre(sent[0].y), sent[0].p));
    drive(1, sent[5].x, sent[5].y, sent[5].p);
    out_ready = 1'b1;
    tick();
    drive(0, 0, 0, 0);
    check("pp_no_drop", {overflow, drop_count}, 9'd0);
    got = 1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (got < 6) begin
          check("pp_order", dut_pk(),
                pk(1, centre(sent[got].x), centre(sent[got].y), sent[got].p));
        end
        got++;
      end
      tick();
    end
    check("pp_count", got, 6);

    // Clear coinciding with a drop, then a plain drop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i, i, 1);
      tick();
    end
    drive(1, -4, 4, 0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_wins", {overflow, drop_count}, 9'd0);
    tick();
    drive(0, 0, 0, 0);
    check("drop_after_clr", {overflow, drop_count}, {1'b1, 8'd1});

    // Reset mid-operation: output held plus 3 queued
    drain(20);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, -i, i, 1);
      tick();
    end
    drive(0, 0, 0, 0);
    check("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", dut_pk(), 20'd0);
    check("async_rst_stats", {overflow, drop_count, range_err_count}, 17'd0);
    tick();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      stale += out_valid;
    end
    check("no_stale", stale, 0);
    single_event("post_reset", -6, 5, 0);

    // Range error counter saturation
    pulse_clr();
    for (int i = 0; i < 260; i++) begin
      drive(1, (i % 2 == 1) ? 8 : -9, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    check("rerr_sat", range_err_count, 8'd255);
    check("rerr_sat_side", {out_valid, overflow, drop_count}, 10'd0);

    // Randomized run against the reference model
    out_ready = 1'b0;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit v, p, rdy, clr;
      int x, y;
      v   = ($urandom % 3) != 0;
      x   = ($urandom % 8 == 0) ? int'($urandom_range(0, 31)) - 16 : int'($urandom_range(0, 15)) - 8;
      y   = ($urandom % 8 == 0) ? int'($urandom_range(0, 31)) - 16 : int'($urandom_range(0, 15)) - 8;
      p   = $urandom % 2;
      rdy = (cyc < 1500) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      clr = ($urandom % 200 == 0);
      drive(v, x, y, p);
      out_ready = rdy;
      clr_stats = clr;
      model_edge(v, x, y, p, rdy, clr);
      tick();
      check("rand_valid", out_valid, m_ov);
      if (m_ov) begin
        check("rand_data", {out_x, out_y, out_polarity},
              {9'(centre(m_out.x)), 9'(centre(m_out.y)), m_out.p});
      end
      check("rand_stats", {overflow, drop_count, range_err_count},
            {m_ovf, 8'(m_drop), 8'(m_rerr)});
    end
    drive(0, 0, 0, 0);
    clr_stats = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
